// File: rtl/wb_pkg.sv
// Shared helpers for the multi-lane writeback stage: lane sizing, popcount, config checks.
package wb_pkg;

  localparam int LANES_MAX   = 4;
  localparam int LANE_CTRL_W = 2;

  function automatic int lane_w(input int rf_aw, input int xlen, input int pc_w);
    return LANE_CTRL_W + rf_aw + xlen + pc_w;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Trace FIFO: up to NPUSH ordered pushes per edge, head shown combinationally, popped every non-empty edge.
// No internal backpressure; the writer must check count_o before pushing.
module wb_trace_fifo
  import wb_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int NPUSH = 2,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NPUSH-1:0]   push_mask_i,
  input  logic [NPUSH*W-1:0] push_dat_i,
  output logic [W-1:0]       head_o,
  output logic               nonempty_o,
  output logic [CW-1:0]      count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] slot [NPUSH];
  logic [2:0]    push_off;
  logic [2:0]    n_push;
  logic          pop;

  function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] p, input logic [2:0] n);
    return AW'((int'(p) + int'(n)) % DEPTH);
  endfunction

  assign pop    = (count_q != '0);
  assign n_push = popcount4(4'(push_mask_i));

  // Masked lanes are compacted so valid entries land in consecutive slots, lowest lane first.
  always_comb begin
    push_off = '0;
    for (int i = 0; i < NPUSH; i++) begin
      slot[i]  = ptr_add(wr_ptr_q, push_off);
      push_off = push_off + {2'b00, push_mask_i[i]};
    end
  end

  always_comb begin
    wr_ptr_d = ptr_add(wr_ptr_q, n_push);
    rd_ptr_d = pop ? ptr_add(rd_ptr_q, 3'd1) : rd_ptr_q;
    count_d  = count_q + CW'(n_push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < NPUSH; i++) begin
        if (push_mask_i[i]) begin
          mem_q[slot[i]] <= push_dat_i[i*W +: W];
        end
      end
    end
  end

  assign head_o     = mem_q[rd_ptr_q];
  assign nonempty_o = pop;
  assign count_o    = count_q;

endmodule

// File: rtl/wb_stage_multi.sv
// Multi-lane writeback: RF writes one cycle after capture, trace records serialised through a FIFO.
// Stalls MEM (wb_allowin=0) while the trace FIFO lacks room for every valid lane of the held group.
module wb_stage_multi
  import wb_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int XLEN        = 32,
  parameter int PC_W        = 32,
  parameter int RF_AW       = 5,
  parameter int TRACE_DEPTH = 4,
  localparam int LW         = lane_w(RF_AW, XLEN, PC_W)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   mem_to_wb_valid,
  output logic                   wb_allowin,
  input  logic [LANES*LW-1:0]    mem_to_wb_bus,
  output logic [LANES-1:0]       wb_rf_we,
  output logic [LANES*RF_AW-1:0] wb_rf_waddr,
  output logic [LANES*XLEN-1:0]  wb_rf_wdata,
  output logic [PC_W-1:0]        debug_wb_pc,
  output logic [3:0]             debug_wb_rf_we,
  output logic [RF_AW-1:0]       debug_wb_rf_wnum,
  output logic [XLEN-1:0]        debug_wb_rf_wdata
);

  localparam int EW = LW - 1;
  localparam int CW = $clog2(TRACE_DEPTH + 1);

  typedef struct packed {
    logic             v;
    logic             we;
    logic [RF_AW-1:0] waddr;
    logic [XLEN-1:0]  wdata;
    logic [PC_W-1:0]  pc;
  } lane_t;

  typedef struct packed {
    logic             we;
    logic [RF_AW-1:0] waddr;
    logic [XLEN-1:0]  wdata;
    logic [PC_W-1:0]  pc;
  } rec_t;

  if (!is_pow2(TRACE_DEPTH) || (TRACE_DEPTH < LANES) || (LANES < 1) || (LANES > LANES_MAX)) begin : g_bad_cfg
    $error("wb_stage_multi: TRACE_DEPTH must be a power of two >= LANES, LANES in 1..4");
  end

  logic [LANES*LW-1:0] grp_q, grp_d;
  logic                wb_valid_q, wb_valid_d;
  lane_t               lane [LANES];
  logic [LANES-1:0]    lane_v;
  logic [LANES-1:0]    keep;
  logic [2:0]          nv;
  logic [CW-1:0]       fifo_count;
  logic                fifo_nonempty;
  logic [EW-1:0]       fifo_head;
  rec_t                head;
  logic                wb_ready_go;
  logic                retire;
  logic [LANES-1:0]    push_mask;
  logic [LANES*EW-1:0] push_dat;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane[i]                         = lane_t'(grp_q[i*LW +: LW]);
      lane_v[i]                       = lane[i].v;
      push_dat[i*EW +: EW]            = grp_q[i*LW +: EW];
      wb_rf_waddr[i*RF_AW +: RF_AW]   = lane[i].waddr;
      wb_rf_wdata[i*XLEN +: XLEN]     = lane[i].wdata;
    end
  end

  // Credit check against the pre-pop count: a same-edge pop is deliberately not counted as room.
  assign nv          = popcount4(4'(lane_v));
  assign wb_ready_go = (TRACE_DEPTH - int'(fifo_count)) >= int'(nv);
  assign wb_allowin  = ~wb_valid_q | wb_ready_go;
  assign retire      = wb_valid_q & wb_ready_go;
  assign push_mask   = retire ? lane_v : '0;

  // Younger lane wins a same-address write, so the regfile never sees two enables for one address.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      keep[i] = 1'b1;
      for (int j = i + 1; j < LANES; j++) begin
        if (lane[j].v && lane[j].we && (lane[j].waddr == lane[i].waddr)) begin
          keep[i] = 1'b0;
        end
      end
      wb_rf_we[i] = retire & lane[i].v & lane[i].we & keep[i];
    end
  end

  always_comb begin
    grp_d      = (mem_to_wb_valid && wb_allowin) ? mem_to_wb_bus : grp_q;
    wb_valid_d = wb_allowin ? mem_to_wb_valid : wb_valid_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grp_q      <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      grp_q      <= grp_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  wb_trace_fifo #(
    .W     (EW),
    .DEPTH (TRACE_DEPTH),
    .NPUSH (LANES)
  ) u_trace_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_mask_i (push_mask),
    .push_dat_i  (push_dat),
    .head_o      (fifo_head),
    .nonempty_o  (fifo_nonempty),
    .count_o     (fifo_count)
  );

  assign head              = rec_t'(fifo_head);
  assign debug_wb_pc       = head.pc;
  assign debug_wb_rf_wnum  = head.waddr;
  assign debug_wb_rf_wdata = head.wdata;
  assign debug_wb_rf_we    = {4{fifo_nonempty & head.we}};

endmodule

// File: tb/tb_wb_stage_multi.sv
// Directed bench for wb_stage_multi: single-group vector table plus streaming, wrap and reset-in-stall sequences.
module tb_wb_stage_multi;

  localparam int LANES = 2;
  localparam int XLEN  = 32;
  localparam int PC_W  = 32;
  localparam int RF_AW = 5;
  localparam int DEPTH = 4;
  localparam int LW    = 2 + RF_AW + XLEN + PC_W;
  localparam int NVEC  = 7;

  logic                   clk = 1'b0;
  logic                   resetn = 1'b1;
  logic                   mem_to_wb_valid = 1'b0;
  logic [LANES*LW-1:0]    mem_to_wb_bus = '0;
  logic                   wb_allowin;
  logic [LANES-1:0]       wb_rf_we;
  logic [LANES*RF_AW-1:0] wb_rf_waddr;
  logic [LANES*XLEN-1:0]  wb_rf_wdata;
  logic [PC_W-1:0]        debug_wb_pc;
  logic [3:0]             debug_wb_rf_we;
  logic [RF_AW-1:0]       debug_wb_rf_wnum;
  logic [XLEN-1:0]        debug_wb_rf_wdata;

  always #5 clk = ~clk;

  wb_stage_multi #(
    .LANES       (LANES),
    .XLEN        (XLEN),
    .PC_W        (PC_W),
    .RF_AW       (RF_AW),
    .TRACE_DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .wb_allowin        (wb_allowin),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .wb_rf_we          (wb_rf_we),
    .wb_rf_waddr       (wb_rf_waddr),
    .wb_rf_wdata       (wb_rf_wdata),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [LW-1:0]    l1;
    logic [LW-1:0]    l0;
    logic [1:0]       rf_we;
    logic [1:0]       ntr;
    logic [1:0][31:0] tpc;
    logic [1:0][3:0]  twe;
    logic [1:0][4:0]  twnum;
    logic [1:0][31:0] twdata;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic logic [LW-1:0] mk(input logic v, input logic we, input logic [4:0] a,
                                       input logic [31:0] d, input logic [31:0] pc);
    return {v, we, a, d, pc};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setv(input int k, input logic [LW-1:0] l0, input logic [LW-1:0] l1,
                      input logic [1:0] rfwe, input logic [1:0] ntr);
    vecs[k]       = '0;
    vecs[k].l0    = l0;
    vecs[k].l1    = l1;
    vecs[k].rf_we = rfwe;
    vecs[k].ntr   = ntr;
  endtask

  task automatic settr(input int k, input int i, input logic [31:0] pc, input logic [3:0] we,
                       input logic [4:0] wnum, input logic [31:0] wdata);
    vecs[k].tpc[i]    = pc;
    vecs[k].twe[i]    = we;
    vecs[k].twnum[i]  = wnum;
    vecs[k].twdata[i] = wdata;
  endtask

  task automatic apply_vec(input int k);
    vec_t          v;
    logic [LW-1:0] ln;
    v = vecs[k];
    @(negedge clk);
    chk($sformatf("v%0d_allowin", k), 64'(wb_allowin), 64'(1));
    mem_to_wb_valid = 1'b1;
    mem_to_wb_bus   = {v.l1, v.l0};
    @(negedge clk);
    mem_to_wb_valid = 1'b0;
    mem_to_wb_bus   = '0;
    chk($sformatf("v%0d_rf_we", k), 64'(wb_rf_we), 64'(v.rf_we));
    chk($sformatf("v%0d_trace_idle", k), 64'(debug_wb_rf_we), 64'(0));
    for (int i = 0; i < LANES; i++) begin
      if (v.rf_we[i]) begin
        ln = (i == 1) ? v.l1 : v.l0;
        chk($sformatf("v%0d_rf_waddr%0d", k, i), 64'(wb_rf_waddr[i*RF_AW +: RF_AW]),
            64'(ln[PC_W+XLEN +: RF_AW]));
        chk($sformatf("v%0d_rf_wdata%0d", k, i), 64'(wb_rf_wdata[i*XLEN +: XLEN]),
            64'(ln[PC_W +: XLEN]));
      end
    end
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      if (t == 0) chk($sformatf("v%0d_rf_no_repeat", k), 64'(wb_rf_we), 64'(0));
      if (t < int'(v.ntr)) begin
        chk($sformatf("v%0d_tr%0d_pc", k, t), 64'(debug_wb_pc), 64'(v.tpc[t]));
        chk($sformatf("v%0d_tr%0d_we", k, t), 64'(debug_wb_rf_we), 64'(v.twe[t]));
        chk($sformatf("v%0d_tr%0d_wnum", k, t), 64'(debug_wb_rf_wnum), 64'(v.twnum[t]));
        chk($sformatf("v%0d_tr%0d_wdata", k, t), 64'(debug_wb_rf_wdata), 64'(v.twdata[t]));
      end else begin
        chk($sformatf("v%0d_tr%0d_none", k, t), 64'(debug_wb_rf_we), 64'(0));
      end
    end
  endtask

  task automatic drive_grp(input int g, input bit dual, input logic [31:0] base_off);
    logic [31:0] base;
    base = dual ? (base_off + 32'(8 * g)) : 32'(4 * g);
    mem_to_wb_valid = 1'b1;
    if (dual)
      mem_to_wb_bus = {mk(1'b1, 1'b1, 5'(2 * g + 2), base + 32'd4, base + 32'd4),
                       mk(1'b1, 1'b1, 5'(2 * g + 1), base, base)};
    else
      mem_to_wb_bus = {mk(1'b0, 1'b0, 5'd0, 32'd0, 32'd0),
                       mk(1'b1, 1'b1, 5'(g + 1), base, base)};
  endtask

  // Streams ngrp groups under valid/ready handshake; checks allowin pattern, RF pulses and trace order.
  task automatic run_stream(input int ngrp, input bit dual);
    logic [31:0] exp_pc [$];
    logic [31:0] base;
    int          g, got, rfg, ntr;
    bit          hs, exp_al;
    g = 0; got = 0; rfg = 0; hs = 1'b0;
    for (int i = 0; i < ngrp; i++) begin
      base = dual ? (32'h1000 + 32'(8 * i)) : 32'(4 * i);
      exp_pc.push_back(base);
      if (dual) exp_pc.push_back(base + 32'd4);
    end
    ntr = exp_pc.size();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c <= 10) begin
        exp_al = dual ? !((c >= 3) && (c <= 9) && (c % 2 == 1)) : 1'b1;
        chk($sformatf("stream%0d_allowin_c%0d", dual, c), 64'(wb_allowin), 64'(exp_al));
      end
      if (wb_rf_we != '0) begin
        chk($sformatf("stream%0d_rf_we_g%0d", dual, rfg), 64'(wb_rf_we), dual ? 64'(2'b11) : 64'(2'b01));
        chk($sformatf("stream%0d_rf_waddr_g%0d", dual, rfg), 64'(wb_rf_waddr[RF_AW-1:0]),
            dual ? 64'(2 * rfg + 1) : 64'(rfg + 1));
        rfg++;
      end
      if (debug_wb_rf_we != '0) begin
        if (got < ntr) chk($sformatf("stream%0d_trace_pc%0d", dual, got), 64'(debug_wb_pc), 64'(exp_pc[got]));
        got++;
      end else if ((got > 0) && (got < ntr)) begin
        chk($sformatf("stream%0d_trace_gap%0d", dual, got), 64'(debug_wb_rf_we), 64'(4'hf));
      end
      if (hs) g++;
      if (g < ngrp) drive_grp(g, dual, 32'h1000);
      else begin
        mem_to_wb_valid = 1'b0;
        mem_to_wb_bus   = '0;
      end
      hs = mem_to_wb_valid & wb_allowin;
    end
    chk($sformatf("stream%0d_rf_groups", dual), 64'(rfg), 64'(ngrp));
    chk($sformatf("stream%0d_trace_count", dual), 64'(got), 64'(ntr));
  endtask

  task automatic reset_mid_stall();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_grp(c, 1'b1, 32'h2000);
    end
    @(negedge clk);
    chk("rst_stall_allowin_before", 64'(wb_allowin), 64'(0));
    mem_to_wb_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("rst_stall_allowin", 64'(wb_allowin), 64'(1));
    chk("rst_stall_rf_we", 64'(wb_rf_we), 64'(0));
    chk("rst_stall_rf_waddr", 64'(wb_rf_waddr), 64'(0));
    chk("rst_stall_rf_wdata", 64'(wb_rf_wdata), 64'(0));
    chk("rst_stall_dbg_we", 64'(debug_wb_rf_we), 64'(0));
    chk("rst_stall_dbg_pc", 64'(debug_wb_pc), 64'(0));
    chk("rst_stall_dbg_wnum", 64'(debug_wb_rf_wnum), 64'(0));
    chk("rst_stall_dbg_wdata", 64'(debug_wb_rf_wdata), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst_after_rf_we%0d", c), 64'(wb_rf_we), 64'(0));
      chk($sformatf("rst_after_dbg_we%0d", c), 64'(debug_wb_rf_we), 64'(0));
    end
    apply_vec(0);
  endtask

  initial begin
    setv(0, mk(1'b1, 1'b1, 5'd4, 32'h11, 32'h1c000000), mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0), 2'b01, 2'd1);
    settr(0, 0, 32'h1c000000, 4'hf, 5'd4, 32'h11);
    setv(1, mk(1'b1, 1'b1, 5'd7, 32'hA, 32'h200), mk(1'b1, 1'b1, 5'd7, 32'hB, 32'h204), 2'b10, 2'd2);
    settr(1, 0, 32'h200, 4'hf, 5'd7, 32'hA);
    settr(1, 1, 32'h204, 4'hf, 5'd7, 32'hB);
    setv(2, mk(1'b1, 1'b0, 5'd9, 32'h55, 32'h100), mk(1'b1, 1'b1, 5'd3, 32'h33, 32'h104), 2'b10, 2'd2);
    settr(2, 0, 32'h100, 4'h0, 5'd9, 32'h55);
    settr(2, 1, 32'h104, 4'hf, 5'd3, 32'h33);
    setv(3, mk(1'b1, 1'b1, 5'd0, 32'h1, 32'h300), mk(1'b1, 1'b1, 5'd0, 32'h2, 32'h304), 2'b10, 2'd2);
    settr(3, 0, 32'h300, 4'hf, 5'd0, 32'h1);
    settr(3, 1, 32'h304, 4'hf, 5'd0, 32'h2);
    setv(4, mk(1'b1, 1'b1, 5'd1, 32'hAA, 32'h400), mk(1'b1, 1'b1, 5'd2, 32'hBB, 32'h404), 2'b11, 2'd2);
    settr(4, 0, 32'h400, 4'hf, 5'd1, 32'hAA);
    settr(4, 1, 32'h404, 4'hf, 5'd2, 32'hBB);
    setv(5, mk(1'b0, 1'b1, 5'd5, 32'h77, 32'h500), mk(1'b0, 1'b1, 5'd5, 32'h78, 32'h504), 2'b00, 2'd0);
    setv(6, mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0), mk(1'b1, 1'b1, 5'd6, 32'h66, 32'h600), 2'b10, 2'd1);
    settr(6, 0, 32'h600, 4'hf, 5'd6, 32'h66);

    #1 resetn = 1'b0;
    #2;
    chk("reset_allowin", 64'(wb_allowin), 64'(1));
    chk("reset_rf_we", 64'(wb_rf_we), 64'(0));
    chk("reset_rf_waddr", 64'(wb_rf_waddr), 64'(0));
    chk("reset_dbg_we", 64'(debug_wb_rf_we), 64'(0));
    chk("reset_dbg_pc", 64'(debug_wb_pc), 64'(0));
    chk("reset_dbg_wnum", 64'(debug_wb_rf_wnum), 64'(0));
    chk("reset_dbg_wdata", 64'(debug_wb_rf_wdata), 64'(0));
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    for (int k = 0; k < NVEC; k++) apply_vec(k);
    run_stream(6, 1'b1);
    run_stream(10, 1'b0);
    reset_mid_stall();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
